led_catcher_game_ctrl: RTL and testbench

Sequencing controller for the LED catcher game. It owns the game flow: arming, target selection, per-round reaction window, hit/miss judgement, score and round counting, and difficulty ramp. It drives the 16 target LEDs from the 16 player switches. Its score and phase outputs feed the existing BCD/display path.

---
 rtl/led_catcher_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_led_catcher_game_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_catcher_game_ctrl.sv
// LED catcher game sequencer: arming, LFSR target pick, reaction window,
// hit/miss judgement, score/round counting and window ramp-down.
module led_catcher_game_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int ROUNDS      = 10,
  parameter int INIT_WINDOW = 20,
  parameter int MIN_WINDOW  = 4,
  parameter int WINDOW_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [7:0]  score,
  output logic [7:0]  round,
  output logic        hit,
  output logic        miss,
  output logic        game_over,
  output logic [2:0]  phase
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    PLAY   = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } phase_e;

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    INIT_W     = 8'(INIT_WINDOW);
  localparam logic [7:0]    MIN_W      = 8'(MIN_WINDOW);
  localparam logic [7:0]    STEP_W     = 8'(WINDOW_STEP);
  localparam logic [8:0]    ROUNDS_W   = 9'(ROUNDS);
  localparam logic [8:0]    STEP_FLOOR = 9'(MIN_WINDOW + WINDOW_STEP);

  // Shrink the window by one step, clamping at the floor before any underflow.
  function automatic logic [7:0] shrink_window(input logic [7:0] w);
    if ({1'b0, w} >= STEP_FLOOR) return w - STEP_W;
    return MIN_W;
  endfunction

  phase_e        phase_q, phase_d;
  logic [4:0]    lfsr_q, lfsr_d;
  logic [15:0]   led_q, led_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
  logic [7:0]    window_q, window_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          game_over_q, game_over_d;

  logic sw_clear, sw_match, sw_wrong, tick_wrap, timeout;
  logic judge_hit, judge_miss, last_round;

  assign lfsr_d     = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  assign sw_clear   = (switch == 16'h0000);
  assign sw_match   = (switch == led_q);
  assign sw_wrong   = !sw_clear && !sw_match;
  assign tick_wrap  = (presc_q == PRESC_LAST);
  assign timeout    = tick_wrap && (({1'b0, elapsed_q} + 9'd1) == {1'b0, window_q});
  // A correct pattern wins over a coincident timeout.
  assign judge_hit  = (phase_q == PLAY) && sw_match;
  assign judge_miss = (phase_q == PLAY) && !sw_match && (sw_wrong || timeout);
  assign last_round = (({1'b0, round_q} + 9'd1) == ROUNDS_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= IDLE;
      lfsr_q      <= 5'b00001;
      led_q       <= '0;
      score_q     <= '0;
      round_q     <= '0;
      window_q    <= INIT_W;
      presc_q     <= '0;
      elapsed_q   <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      lfsr_q      <= lfsr_d;
      led_q       <= led_d;
      score_q     <= score_d;
      round_q     <= round_d;
      window_q    <= window_d;
      presc_q     <= presc_d;
      elapsed_q   <= elapsed_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE, DONE: if (start) phase_d = ARM;
      ARM:        if (sw_clear) phase_d = PLAY;
      PLAY:       if (judge_hit || judge_miss) phase_d = RESULT;
      RESULT:     if (sw_clear) phase_d = last_round ? DONE : PLAY;
      default:    phase_d = IDLE;
    endcase
  end

  always_comb begin
    led_d       = led_q;
    score_d     = score_q;
    round_d     = round_q;
    window_d    = window_q;
    presc_d     = presc_q;
    elapsed_d   = elapsed_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    game_over_d = (phase_d == DONE);
    case (phase_q)
      IDLE, DONE: begin
        if (start) begin
          score_d  = '0;
          round_d  = '0;
          window_d = INIT_W;
        end
      end
      PLAY: begin
        if (tick_wrap) begin
          presc_d   = '0;
          elapsed_d = elapsed_q + 8'd1;
        end else begin
          presc_d   = presc_q + PW'(1);
        end
        if (judge_hit) begin
          hit_d    = 1'b1;
          score_d  = score_q + 8'd1;
          window_d = shrink_window(window_q);
          led_d    = '0;
        end else if (judge_miss) begin
          miss_d   = 1'b1;
          led_d    = '0;
        end
      end
      RESULT: if (sw_clear) round_d = round_q + 8'd1;
      default: ;
    endcase
    // Every entry into PLAY picks a fresh target and restarts the window timing.
    if ((phase_d == PLAY) && (phase_q != PLAY)) begin
      led_d     = 16'd1 << lfsr_q[3:0];
      presc_d   = '0;
      elapsed_d = '0;
    end
  end

  assign led       = led_q;
  assign score     = score_q;
  assign round     = round_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign game_over = game_over_q;
  assign phase     = phase_q;
endmodule

// File: tb/tb_led_catcher_game_ctrl.sv
// Directed bench for led_catcher_game_ctrl with small tick/round/window settings.
module tb_led_catcher_game_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int ROUNDS      = 3;
  localparam int INIT_WINDOW = 5;
  localparam int MIN_WINDOW  = 2;
  localparam int WINDOW_STEP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] switch;
  logic [15:0] led;
  logic [7:0]  score;
  logic [7:0]  round;
  logic        hit;
  logic        miss;
  logic        game_over;
  logic [2:0]  phase;

  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  lfsr_m, lfsr_prev;
  logic [15:0] cur_led;
  logic [15:0] wrong;

  led_catcher_game_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .ROUNDS     (ROUNDS),
    .INIT_WINDOW(INIT_WINDOW),
    .MIN_WINDOW (MIN_WINDOW),
    .WINDOW_STEP(WINDOW_STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .switch   (switch),
    .led      (led),
    .score    (score),
    .round    (round),
    .hit      (hit),
    .miss     (miss),
    .game_over(game_over),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Reference x^5+x^3+1 sequence; lfsr_prev is the value seen by the last edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m    <= 5'b00001;
      lfsr_prev <= 5'b00001;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[3:0], lfsr_m[4] ^ lfsr_m[2]};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic enter_play(input string tag);
    cur_led = 16'd1 << lfsr_prev[3:0];
    chk({tag, "_phase"}, 32'(phase), 32'd2);
    chk({tag, "_led"}, 32'(led), 32'(cur_led));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; switch = 16'h0000;
    tick(); tick();
    rst = 1'b0;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_gover", 32'(game_over), 32'd0);

    // Reach PLAY, then reset asynchronously between edges
    start = 1'b1; tick(); chk("a_arm", 32'(phase), 32'd1);
    start = 1'b0; tick(); enter_play("a_play");
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_led", 32'(led), 32'd0);
    chk("async_score", 32'(score), 32'd0);
    chk("async_round", 32'(round), 32'd0);
    chk("async_hitmiss", 32'({hit, miss, game_over}), 32'd0);
    #2 rst = 1'b0;

    // Game 1: arm held off by a raised switch, then three hits
    start = 1'b1; switch = 16'h0001;
    tick(); chk("g1_arm", 32'(phase), 32'd1);
    start = 1'b0;
    tick(); chk("g1_arm_hold1", 32'(phase), 32'd1);
    tick(); chk("g1_arm_hold2", 32'(phase), 32'd1);
    switch = 16'h0000;
    tick(); enter_play("g1_r0");
    for (int r = 0; r < 3; r++) begin
      tick(); tick();
      switch = cur_led;
      tick();
      chk("g1_hit", 32'(hit), 32'd1);
      chk("g1_nomiss", 32'(miss), 32'd0);
      chk("g1_score", 32'(score), 32'(r + 1));
      chk("g1_result", 32'(phase), 32'd3);
      chk("g1_led_off", 32'(led), 32'd0);
      switch = 16'h0000;
      tick();
      chk("g1_hit_drop", 32'(hit), 32'd0);
      chk("g1_round", 32'(round), 32'(r + 1));
      if (r < 2) enter_play("g1_next");
    end
    chk("g1_done_phase", 32'(phase), 32'd4);
    chk("g1_done_gover", 32'(game_over), 32'd1);
    chk("g1_done_score", 32'(score), 32'd3);

    // Restart from DONE; game 2 checks the clamped window via the final timeout
    start = 1'b1;
    tick();
    chk("rs_phase", 32'(phase), 32'd1);
    chk("rs_score", 32'(score), 32'd0);
    chk("rs_round", 32'(round), 32'd0);
    chk("rs_gover", 32'(game_over), 32'd0);
    start = 1'b0;
    tick(); enter_play("g2_r0");
    switch = cur_led; tick(); chk("g2_h0", 32'(hit), 32'd1);
    switch = 16'h0000; tick(); enter_play("g2_r1");
    switch = cur_led; tick(); chk("g2_h1", 32'(score), 32'd2);
    switch = 16'h0000; tick(); enter_play("g2_r2");
    repeat (7) tick();
    chk("g2_pre_to_phase", 32'(phase), 32'd2);
    chk("g2_pre_to_miss", 32'(miss), 32'd0);
    tick();
    chk("g2_to_miss", 32'(miss), 32'd1);
    chk("g2_to_hit", 32'(hit), 32'd0);
    chk("g2_to_score", 32'(score), 32'd2);
    tick();
    chk("g2_done", 32'({phase, round, game_over}), 32'({3'd4, 8'd3, 1'b1}));

    // Game 3: full-window timeout, wrong switch with start held, coincident hit
    start = 1'b1; tick(); start = 1'b0;
    tick(); enter_play("g3_r0");
    repeat (19) tick();
    chk("g3_pre_to", 32'({phase, miss}), 32'({3'd2, 1'b0}));
    tick();
    chk("g3_to_miss", 32'(miss), 32'd1);
    chk("g3_to_score", 32'(score), 32'd0);
    tick(); enter_play("g3_r1");
    chk("g3_r1_round", 32'(round), 32'd1);
    wrong = (cur_led == 16'h8000) ? (cur_led | 16'h0001) : (cur_led | 16'h8000);
    start = 1'b1; switch = wrong;
    tick();
    chk("g3_wrong_miss", 32'(miss), 32'd1);
    chk("g3_wrong_hit", 32'(hit), 32'd0);
    chk("g3_wrong_phase", 32'(phase), 32'd3);
    chk("g3_wrong_score", 32'(score), 32'd0);
    tick();
    chk("g3_res_hold", 32'({phase, round, miss}), 32'({3'd3, 8'd1, 1'b0}));
    switch = 16'h0000;
    tick(); enter_play("g3_r2");
    chk("g3_r2_round", 32'(round), 32'd2);
    repeat (19) tick();
    chk("g3_start_ignored", 32'(phase), 32'd2);
    start = 1'b0; switch = cur_led;
    tick();
    chk("g3_sim_hit", 32'(hit), 32'd1);
    chk("g3_sim_miss", 32'(miss), 32'd0);
    chk("g3_sim_score", 32'(score), 32'd1);
    switch = 16'h0000;
    tick();
    chk("g3_done", 32'({phase, round, game_over, score}), 32'({3'd4, 8'd3, 1'b1, 8'd1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
